// File: rtl/rr_link_pkg.sv
// rtl/rr_link_pkg.sv - shared types and constants for the round-robin link arbiter
package rr_link_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam int NREQ_DEF    = 4;
   localparam int DW_DEF      = 8;
   localparam int TIMEOUT_DEF = 16;
   localparam int TO_W        = 8;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: first set request at or after ptr, wrapping
module rr_pick
   import rr_link_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   localparam int IW  = idx_w(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   idx,
   output logic            any
);

   logic [IW-1:0] j;

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      j   = '0;
      for (int i = 0; i < NREQ; i++) begin
         j = IW'((int'(ptr) + i) % NREQ);
         if (!any && req[j]) begin
            any    = 1'b1;
            gnt[j] = 1'b1;
            idx    = j;
         end
      end
   end

endmodule

// File: rtl/rr_link_arbiter.sv
// rtl/rr_link_arbiter.sv - packet round-robin arbiter onto one registered link; ARB_TIMEOUT_EN adds stall release
module rr_link_arbiter
   import rr_link_pkg::*;
#(
   parameter int NREQ    = NREQ_DEF,
   parameter int DW      = DW_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*DW-1:0] req_data,
   input  logic [NREQ-1:0]    req_last,
   output logic [NREQ-1:0]    req_ready,
   output logic             out_valid,
   output logic [DW-1:0]    out_data,
   output logic             out_last,
   input  logic             out_ready,
   output logic [NREQ-1:0]  grant,
   output logic             busy,
   output logic             err_timeout
);

   localparam int IW = idx_w(NREQ);

   state_t          state, state_nxt;
   logic [IW-1:0]   ptr, gidx;
   logic [NREQ-1:0] pick_gnt;
   logic [IW-1:0]   pick_idx;
   logic            pick_any;
   logic            own_valid, own_last, own_ready;
   logic [DW-1:0]   own_data;
   logic            xfer, pkt_end, timeout_hit;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req (req_valid),
      .ptr (ptr),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   always_comb begin
      own_valid = 1'b0;
      own_last  = 1'b0;
      own_data  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gidx == IW'(i)) begin
            own_valid = req_valid[i];
            own_last  = req_last[i];
            own_data  = req_data[i*DW +: DW];
         end
      end
   end

   assign xfer    = own_ready & own_valid;
   assign pkt_end = xfer & own_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_any) state_nxt = BUSY;
         BUSY:    if (pkt_end || timeout_hit) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Owner may push whenever the output register is empty or draining this cycle.
   always_comb begin
      own_ready = 1'b0;
      if (state == BUSY) own_ready = out_ready | ~out_valid;
      req_ready = grant & {NREQ{own_ready}};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant <= '0;
         gidx  <= '0;
         ptr   <= '0;
         busy  <= 1'b0;
      end else begin
         busy <= (state_nxt == BUSY);
         if (state == IDLE && pick_any) begin
            grant <= pick_gnt;
            gidx  <= pick_idx;
         end else if (state == BUSY && (pkt_end || timeout_hit)) begin
            grant <= '0;
            ptr   <= (gidx == IW'(NREQ-1)) ? '0 : gidx + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= own_data;
         out_last  <= own_last;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
   logic [TO_W-1:0] stall_cnt;

   assign timeout_hit = (state == BUSY) && !own_valid && (stall_cnt == TO_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt   <= '0;
         err_timeout <= 1'b0;
      end else begin
         err_timeout <= timeout_hit;
         if (state != BUSY || own_valid || timeout_hit) stall_cnt <= '0;
         else                                          stall_cnt <= stall_cnt + 1'b1;
      end
   end
`else
   // No stall counter: folds to 0 for any legal TIMEOUT, grant held until the last beat.
   assign timeout_hit = (TIMEOUT < 0);
   assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_link_arbiter.sv
// tb/tb_rr_link_arbiter.sv - scoreboard bench for rr_link_arbiter
module tb_rr_link_arbiter;

   localparam int NREQ = 4;
   localparam int DW   = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NREQ-1:0]   req_valid, req_last, req_ready, grant;
   logic [NREQ*DW-1:0] req_data;
   logic              out_valid, out_last, out_ready, busy, err_timeout;
   logic [DW-1:0]     out_data;

   int n_checks = 0;
   int n_fail   = 0;
   bit mon_en   = 1'b0;

   logic [DW:0]     src_q [NREQ][$];
   logic [DW:0]     exp_beats [$];
   logic [NREQ-1:0] exp_grants [$];
   logic [NREQ-1:0] prev_grant = '0;

   always #5 clk = ~clk;

   rr_link_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_last    (out_last),
      .out_ready   (out_ready),
      .grant       (grant),
      .busy        (busy),
      .err_timeout (err_timeout)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic bit src_empty();
      for (int i = 0; i < NREQ; i++) if (src_q[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic wait_drain(input string name, input int max_cyc);
      int k;
      bit done;
      k = 0;
      done = 1'b0;
      while (!done && k < max_cyc) begin
         @(negedge clk);
         k++;
         done = !busy && !out_valid && exp_beats.size() == 0 && src_empty();
      end
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: not drained after %0d cycles", name, max_cyc);
      end
   endtask

   // Requester models: present queue head, pop on accepted beat.
   initial begin
      logic [NREQ-1:0] fire;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      forever begin
         @(negedge clk);
         fire = req_valid & req_ready;
         @(posedge clk);
         #1;
         for (int i = 0; i < NREQ; i++) begin
            if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (src_q[i].size() > 0) begin
               req_valid[i]          = 1'b1;
               req_data[i*DW +: DW]  = src_q[i][0][DW-1:0];
               req_last[i]           = src_q[i][0][DW];
            end else begin
               req_valid[i] = 1'b0;
               req_last[i]  = 1'b0;
            end
         end
      end
   end

   // Output monitor: checks every accepted beat and every new grant against the queues.
   initial begin
      logic [DW:0]     eb;
      logic [NREQ-1:0] eg;
      forever begin
         @(negedge clk);
         if (mon_en && rst_n) begin
            if (out_valid && out_ready) begin
               if (exp_beats.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL beat_extra: got %0h expected none", {out_last, out_data});
               end else begin
                  eb = exp_beats.pop_front();
                  chk("beat", 32'({out_last, out_data}), 32'(eb));
               end
            end
            if (grant !== prev_grant && grant !== '0) begin
               if (exp_grants.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL grant_extra: got %0h expected none", grant);
               end else begin
                  eg = exp_grants.pop_front();
                  chk("grant_order", 32'(grant), 32'(eg));
               end
            end
         end
         prev_grant = grant;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int err_cnt;
      out_ready = 1'b1;
      rst_n     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_out_last", 32'(out_last), 0);
      chk("rst_grant", 32'(grant), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_err", 32'(err_timeout), 0);
      chk("rst_req_ready", 32'(req_ready), 0);
      @(posedge clk);
      #3 rst_n = 1'b1;

      // Mid-packet reset on requester 2.
      src_q[2].push_back({1'b0, 8'h21});
      src_q[2].push_back({1'b0, 8'h22});
      src_q[2].push_back({1'b1, 8'h23});
      k = 0;
      do begin @(negedge clk); k++; end while (!out_valid && k < 10);
      chk("a_out_valid_seen", 32'(out_valid), 1);
      rst_n = 1'b0;
      #1;
      chk("a_out_valid", 32'(out_valid), 0);
      chk("a_out_data", 32'(out_data), 0);
      chk("a_grant", 32'(grant), 0);
      chk("a_busy", 32'(busy), 0);
      chk("a_req_ready", 32'(req_ready), 0);
      for (int i = 0; i < NREQ; i++) src_q[i].delete();
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      mon_en = 1'b1;

      // Requester 0 after reset, with latency checks.
      @(posedge clk);
      #2;
      exp_grants.push_back(4'b0001);
      exp_beats.push_back({1'b0, 8'h10});
      exp_beats.push_back({1'b1, 8'h11});
      src_q[0].push_back({1'b0, 8'h10});
      src_q[0].push_back({1'b1, 8'h11});
      @(posedge clk);
      @(posedge clk);
      #2;
      chk("b_grant_lat", 32'(grant), 32'h1);
      chk("b_out_valid_early", 32'(out_valid), 0);
      @(posedge clk);
      #2;
      chk("b_out_valid", 32'(out_valid), 1);
      chk("b_out_data", 32'(out_data), 32'h10);
      wait_drain("b_drain", 20);

      // Fairness: pointer is 1, all four requesters send two 2-beat packets.
      for (int r = 0; r < NREQ; r++)
         for (int p = 0; p < 2; p++)
            for (int b = 0; b < 2; b++)
               src_q[r].push_back({b[0], 8'(r*16 + p*2 + b)});
      for (int p = 0; p < 2; p++)
         for (int n = 1; n <= NREQ; n++) begin
            exp_grants.push_back(4'b0001 << (n % NREQ));
            for (int b = 0; b < 2; b++)
               exp_beats.push_back({b[0], 8'((n % NREQ)*16 + p*2 + b)});
         end
      wait_drain("c_drain", 200);

      // Back-pressure on a 3-beat packet from requester 2.
      exp_grants.push_back(4'b0100);
      exp_beats.push_back({1'b0, 8'hA1});
      exp_beats.push_back({1'b0, 8'hA2});
      exp_beats.push_back({1'b1, 8'hA3});
      src_q[2].push_back({1'b0, 8'hA1});
      src_q[2].push_back({1'b0, 8'hA2});
      src_q[2].push_back({1'b1, 8'hA3});
      k = 0;
      do begin @(negedge clk); k++; end while (!out_valid && k < 10);
      chk("d_first", 32'(out_data), 32'hA1);
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      chk("d_hold_data", 32'(out_data), 32'hA2);
      chk("d_hold_ready", 32'(req_ready), 0);
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      chk("d_hold_data2", 32'(out_data), 32'hA2);
      @(posedge clk);
      #1 out_ready = 1'b1;
      wait_drain("d_drain", 30);

      // Wrap-around: pointer is 3, requests 0 and 1.
      exp_grants.push_back(4'b0001);
      exp_grants.push_back(4'b0010);
      exp_beats.push_back({1'b1, 8'h30});
      exp_beats.push_back({1'b1, 8'h31});
      src_q[0].push_back({1'b1, 8'h30});
      src_q[1].push_back({1'b1, 8'h31});
      wait_drain("e_drain", 30);

      // Back-to-back single-beat packets from requester 1.
      for (int n = 0; n < 4; n++) begin
         exp_grants.push_back(4'b0010);
         exp_beats.push_back({1'b1, 8'(8'h41 + n)});
         src_q[1].push_back({1'b1, 8'(8'h41 + n)});
      end
      k = 0;
      do begin @(negedge clk); k++; end while (!busy && k < 20);
      for (int c = 0; c < 7; c++) begin
         chk("f_busy", 32'(busy), (c % 2 == 0) ? 32'd1 : 32'd0);
         chk("f_grant", 32'(grant), (c % 2 == 0) ? 32'h2 : 32'h0);
         @(negedge clk);
      end
      wait_drain("f_drain", 30);

      // Owner stalls mid-packet while requester 1 waits.
      exp_grants.push_back(4'b0001);
      exp_grants.push_back(4'b0010);
      exp_beats.push_back({1'b0, 8'h50});
      src_q[0].push_back({1'b0, 8'h50});
      src_q[1].push_back({1'b1, 8'h60});
      err_cnt = 0;
`ifdef ARB_TIMEOUT_EN
      exp_beats.push_back({1'b1, 8'h60});
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (err_timeout) err_cnt++;
      end
      chk("g_err_pulses", 32'(err_cnt), 1);
`else
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (err_timeout) err_cnt++;
      end
      chk("g_err_pulses", 32'(err_cnt), 0);
      chk("g_grant_held", 32'(grant), 32'h1);
      chk("g_busy_held", 32'(busy), 1);
      exp_beats.push_back({1'b1, 8'h51});
      exp_beats.push_back({1'b1, 8'h60});
      src_q[0].push_back({1'b1, 8'h51});
`endif
      wait_drain("g_drain", 40);

      chk("end_beats_left", 32'(exp_beats.size()), 0);
      chk("end_grants_left", 32'(exp_grants.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
